// File: rtl/pipe_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package pipe_pkg;
   localparam int WORD_W = 32;
   localparam int REG_W  = 5;
   localparam logic [1:0] ALIGN_MASK = 2'b00;

   typedef enum logic {MEM_IDLE = 1'b0, MEM_WAIT = 1'b1} mem_state_e;

   // Memory access captured from EX while the request is outstanding
   typedef struct packed {
      logic [WORD_W-1:0] ans;
      logic [REG_W-1:0]  rw;
      logic [WORD_W-1:0] wdata;
      logic              we;
   } mem_req_t;

   // MEM/WB register contents
   typedef struct packed {
      logic [WORD_W-1:0] ans;
      logic [WORD_W-1:0] mdata;
      logic [REG_W-1:0]  rw;
      logic              wreg;
      logic              m2reg;
      logic              exc;
   } wb_t;

   function automatic logic word_aligned(input logic [1:0] lsb);
      return lsb == ALIGN_MASK;
   endfunction
endpackage

// File: rtl/stage_mem_if.sv
// Data-memory req/ack bus between the MEM stage and data memory.
interface stage_mem_if #(parameter int AW = 32);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic          ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/stage_mem_reg.sv
// MEM/WB output register bank; valid is a per-cycle strobe, the rest hold unless loaded.
module stage_mem_reg
   import pipe_pkg::*;
(
   input  logic clk,
   input  logic clrn,
   input  logic ld,
   input  logic ld_mdata,
   input  logic valid_d,
   input  wb_t  d,
   output wb_t  q,
   output logic valid
);
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         q     <= '0;
         valid <= 1'b0;
      end else begin
         valid <= valid_d;
         if (ld) begin
            q.ans   <= d.ans;
            q.rw    <= d.rw;
            q.wreg  <= d.wreg;
            q.m2reg <= d.m2reg;
            q.exc   <= d.exc;
         end
         if (ld_mdata) q.mdata <= d.mdata;
      end
   end
endmodule

// File: rtl/stage_mem.sv
// MIPS MEM stage: retires ALU results directly, runs loads/stores over req/ack and stalls upstream meanwhile.
module stage_mem
   import pipe_pkg::*;
#(parameter int AW = 32)
(
   input  logic              clk,
   input  logic              clrn,
   input  logic              valid_ex,
   input  logic [WORD_W-1:0] ans_ex,
   input  logic [WORD_W-1:0] b_ex,
   input  logic [REG_W-1:0]  rw_ex,
   input  logic              wreg_ex,
   input  logic              m2reg_ex,
   input  logic              wmem_ex,
   stage_mem_if.master       dmem,
   output logic              stall_mem,
   output logic              valid_mem,
   output logic [WORD_W-1:0] ans_mem,
   output logic [WORD_W-1:0] mdata_mem,
   output logic [REG_W-1:0]  rw_mem,
   output logic              wreg_mem,
   output logic              m2reg_mem,
   output logic              exc_mem
);
   mem_state_e state;
   mem_req_t   cap;
   logic       req;
   logic       mem_op, start;
   logic       ld, ld_mdata, valid_d;
   wb_t        d, q;

   assign mem_op = m2reg_ex | wmem_ex;
   assign start  = (state == MEM_IDLE) & valid_ex & mem_op & word_aligned(ans_ex[1:0]);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= MEM_IDLE;
         cap   <= '0;
         req   <= 1'b0;
      end else begin
         case (state)
            MEM_IDLE: if (start) begin
               state <= MEM_WAIT;
               req   <= 1'b1;
               // wmem wins when both flags are set
               cap   <= '{ans: ans_ex, rw: rw_ex, wdata: b_ex, we: wmem_ex};
            end
            MEM_WAIT: if (dmem.ack) begin
               state <= MEM_IDLE;
               req   <= 1'b0;
            end
            default: state <= MEM_IDLE;
         endcase
      end
   end

   assign stall_mem  = (state == MEM_WAIT);
   assign dmem.req   = req;
   assign dmem.we    = req & cap.we;
   assign dmem.addr  = {cap.ans[AW-1:2], ALIGN_MASK};
   assign dmem.wdata = cap.wdata;

   always_comb begin
      d        = '0;
      ld       = 1'b0;
      ld_mdata = 1'b0;
      valid_d  = 1'b0;
      if (state == MEM_WAIT) begin
         if (dmem.ack) begin
            ld       = 1'b1;
            valid_d  = 1'b1;
            ld_mdata = ~cap.we;
            d.ans    = cap.ans;
            d.rw     = cap.rw;
            d.mdata  = dmem.rdata;
            d.m2reg  = ~cap.we;
            d.wreg   = ~cap.we & (cap.rw != '0);
         end
      end else if (valid_ex && !start) begin
         // ALU op or misaligned access retires next edge
         ld      = 1'b1;
         valid_d = 1'b1;
         d.ans   = ans_ex;
         d.rw    = rw_ex;
         d.exc   = mem_op;
         d.wreg  = ~mem_op & wreg_ex & (rw_ex != '0);
      end
   end

   stage_mem_reg u_reg (
      .clk      (clk),
      .clrn     (clrn),
      .ld       (ld),
      .ld_mdata (ld_mdata),
      .valid_d  (valid_d),
      .d        (d),
      .q        (q),
      .valid    (valid_mem)
   );

   assign ans_mem   = q.ans;
   assign mdata_mem = q.mdata;
   assign rw_mem    = q.rw;
   assign wreg_mem  = q.wreg;
   assign m2reg_mem = q.m2reg;
   assign exc_mem   = q.exc;
endmodule

// File: tb/tb_stage_mem.sv
// Scoreboard bench for stage_mem: directed plan items then randomized traffic against a memory model.
module tb_stage_mem;
   typedef struct packed {
      logic [31:0] ans;
      logic [31:0] mdata;
      logic [4:0]  rw;
      logic        wreg;
      logic        m2reg;
      logic        exc;
   } exp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } rq_t;

   logic        clk = 1'b0;
   logic        clrn = 1'b0;
   logic        valid_ex = 1'b0;
   logic [31:0] ans_ex = '0, b_ex = '0;
   logic [4:0]  rw_ex = '0;
   logic        wreg_ex = 1'b0, m2reg_ex = 1'b0, wmem_ex = 1'b0;
   logic        stall_mem, valid_mem, wreg_mem, m2reg_mem, exc_mem;
   logic [31:0] ans_mem, mdata_mem;
   logic [4:0]  rw_mem;

   stage_mem_if #(.AW(32)) dmem ();

   stage_mem #(.AW(32)) dut (
      .clk(clk), .clrn(clrn), .valid_ex(valid_ex), .ans_ex(ans_ex), .b_ex(b_ex),
      .rw_ex(rw_ex), .wreg_ex(wreg_ex), .m2reg_ex(m2reg_ex), .wmem_ex(wmem_ex),
      .dmem(dmem.master), .stall_mem(stall_mem), .valid_mem(valid_mem),
      .ans_mem(ans_mem), .mdata_mem(mdata_mem), .rw_mem(rw_mem),
      .wreg_mem(wreg_mem), .m2reg_mem(m2reg_mem), .exc_mem(exc_mem)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];
   rq_t  req_q[$];
   logic [31:0] ref_mem[int unsigned];
   logic [31:0] sim_mem[int unsigned];
   logic [31:0] last_md = '0;
   int  force_lat = -1;
   bit  manual = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   // Reference: what the stage must retire, derived from the instruction alone
   task automatic issue(input logic v, input logic [31:0] ans, input logic [31:0] b,
                        input logic [4:0] rw, input logic wreg, input logic m2reg, input logic wmem);
      int guard = 0;
      logic [31:0] a, val;
      @(negedge clk);
      while (stall_mem && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) chk("stall_timeout", 128'(stall_mem), 128'(0));
      valid_ex = v; ans_ex = ans; b_ex = b; rw_ex = rw;
      wreg_ex = wreg; m2reg_ex = m2reg; wmem_ex = wmem;
      a = {ans[31:2], 2'b00};
      if (v) begin
         if (!m2reg && !wmem)
            exp_q.push_back('{ans, last_md, rw, wreg && rw != 0, 1'b0, 1'b0});
         else if (ans[1:0] != 2'b00)
            exp_q.push_back('{ans, last_md, rw, 1'b0, 1'b0, 1'b1});
         else if (wmem) begin
            req_q.push_back('{a, 1'b1, b});
            ref_mem[a] = b;
            exp_q.push_back('{ans, last_md, rw, 1'b0, 1'b0, 1'b0});
         end else begin
            val = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
            req_q.push_back('{a, 1'b0, b});
            exp_q.push_back('{ans, val, rw, rw != 0, 1'b1, 1'b0});
            last_md = val;
         end
      end
      @(posedge clk);
      #1 valid_ex = 1'b0;
   endtask

   // Monitor: every valid_mem strobe must match the oldest expected retire
   initial begin
      exp_t e, got;
      forever begin
         @(negedge clk);
         if (clrn && valid_mem) begin
            got = '{ans_mem, mdata_mem, rw_mem, wreg_mem, m2reg_mem, exc_mem};
            if (exp_q.size() == 0) chk("unexpected_retire", 128'(got), 128'(0));
            else begin
               e = exp_q.pop_front();
               chk("retire", 128'(got), 128'(e));
               chk("stall_after_retire", 128'(stall_mem), 128'(0));
            end
         end
      end
   end

   // Memory responder with configurable latency
   initial begin
      bit busy = 0;
      int cnt = 0, lat = 0, wc = 0;
      rq_t got;
      dmem.ack = 1'b0;
      dmem.rdata = '0;
      forever begin
         @(negedge clk);
         if (manual) begin busy = 0; continue; end
         dmem.ack = 1'b0;
         dmem.rdata = $urandom;
         if (!clrn) begin busy = 0; continue; end
         if (dmem.req && !busy) begin
            busy = 1; wc = 0;
            lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            cnt = lat;
            got = '{dmem.addr, dmem.we, dmem.wdata};
            if (req_q.size() == 0) chk("unexpected_req", 128'(got), 128'(0));
            else chk("mem_req", 128'(got), 128'(req_q.pop_front()));
         end
         if (busy) begin
            if (stall_mem) wc++;
            if (cnt == 0) begin
               chk("wait_cycles", 128'(wc), 128'(lat + 1));
               if (dmem.we) sim_mem[dmem.addr] = dmem.wdata;
               else dmem.rdata = sim_mem.exists(dmem.addr) ? sim_mem[dmem.addr] : dflt(dmem.addr);
               dmem.ack = 1'b1;
               busy = 0;
            end else cnt--;
         end
      end
   end

   task automatic model_reset();
      exp_q.delete();
      req_q.delete();
      last_md = '0;
   endtask

   initial begin
      int guard;
      logic [31:0] ans;
      int kind;
      bit mis;
      // Reset with a load presented on EX
      clrn = 1'b0; valid_ex = 1'b1; m2reg_ex = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 128'({dmem.req, dmem.we, dmem.addr, dmem.wdata, stall_mem, valid_mem,
          ans_mem, mdata_mem, rw_mem, wreg_mem, m2reg_mem, exc_mem}), 128'(0));
      valid_ex = 1'b0; m2reg_ex = 1'b0;
      clrn = 1'b1;
      @(negedge clk);
      chk("idle_after_reset", 128'({stall_mem, dmem.req, valid_mem}), 128'(0));

      issue(1, 32'h0000_1234, 32'h0, 5'd8, 1, 0, 0);
      issue(1, 32'h0000_1234, 32'h0, 5'd0, 1, 0, 0);

      ref_mem[32'h100] = 32'hDEAD_BEEF;
      sim_mem[32'h100] = 32'hDEAD_BEEF;
      force_lat = 2;
      issue(1, 32'h0000_0100, 32'h0, 5'd9, 1, 1, 0);
      force_lat = 0;
      issue(1, 32'h0000_0200, 32'hCAFE_F00D, 5'd4, 0, 0, 1);
      issue(1, 32'h0000_0102, 32'h0, 5'd7, 1, 1, 0);
      force_lat = -1;

      // Reset during the second WAIT cycle aborts the load
      force_lat = 6;
      issue(1, 32'h0000_0300, 32'h0, 5'd3, 1, 1, 0);
      @(posedge clk);
      manual = 1'b1;
      #1 clrn = 1'b0;
      #1 chk("abort_req_stall", 128'({dmem.req, stall_mem, valid_mem}), 128'(0));
      model_reset();
      dmem.ack = 1'b0;
      @(negedge clk);
      clrn = 1'b1;
      @(negedge clk);
      dmem.ack = 1'b1; dmem.rdata = 32'h1111_2222;
      @(negedge clk);
      dmem.ack = 1'b0;
      chk("late_ack_ignored", 128'({valid_mem, stall_mem, dmem.req}), 128'(0));
      @(negedge clk);
      chk("late_ack_idle", 128'({valid_mem, stall_mem}), 128'(0));
      manual = 1'b0;
      force_lat = -1;

      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 9);
         mis  = ($urandom_range(0, 99) < 15);
         ans  = (kind >= 5) ? ({$urandom_range(0, 15), 2'b00} | (mis ? $urandom_range(1, 3) : 0))
                            : $urandom;
         issue(kind != 0, ans, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               kind == 5 || kind == 6 || kind == 9, kind == 7 || kind == 8 || kind == 9);
      end

      guard = 0;
      while ((exp_q.size() != 0 || req_q.size() != 0) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("drain", 128'({exp_q.size(), req_q.size()}), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
